// File: rtl/injector_stage.sv
// rtl/injector_stage.sv - MinBD injection stage: local flit FIFO feeding the first empty channel slot
// Channel outputs, inj_done and starve are registered; inj_ready comes from registered occupancy only.
module injector_stage #(
    parameter int FLIT_W     = 11,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLIT_W-1:0]          northad,
    input  logic [FLIT_W-1:0]          southad,
    input  logic [FLIT_W-1:0]          eastad,
    input  logic [FLIT_W-1:0]          westad,
    input  logic [FLIT_W-1:0]          inj_flit,
    input  logic                       inj_valid,
    output logic                       inj_ready,
    output logic [FLIT_W-1:0]          nout,
    output logic [FLIT_W-1:0]          sout,
    output logic [FLIT_W-1:0]          eout,
    output logic [FLIT_W-1:0]          wout,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       inj_done,
    output logic                       starve
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [OW-1:0]     count;
    logic [CW-1:0]     starve_cnt;
    logic [CW-1:0]     starve_cnt_next;

    logic [FLIT_W-1:0] slot_in  [4];
    logic [FLIT_W-1:0] slot_out [4];
    logic [3:0]        slot_empty;
    logic              fifo_nonempty;
    logic              push_en;
    logic              pop_en;
    logic              placed;

    assign slot_in[0] = northad;
    assign slot_in[1] = southad;
    assign slot_in[2] = eastad;
    assign slot_in[3] = westad;

    assign inj_ready     = (count != OW'(DEPTH));
    assign occ           = count;
    assign fifo_nonempty = (count != '0);

    // A gs==00 flit completes the handshake but is never stored: it would look like an empty slot.
    assign push_en = inj_valid && inj_ready && (inj_flit[FLIT_W-1 -: 2] != 2'b00);
    assign pop_en  = fifo_nonempty && (slot_empty != 4'b0000);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_empty[i] = (slot_in[i][FLIT_W-1 -: 2] == 2'b00);
        end
    end

    // Head goes into the first empty slot in N, S, E, W order; everything else passes through.
    always_comb begin
        placed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slot_out[i] = slot_in[i];
            if (pop_en && !placed && slot_empty[i]) begin
                slot_out[i] = mem[rd_ptr];
                placed      = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt;
        if (pop_en || !fifo_nonempty) begin
            starve_cnt_next = '0;
        end else if (starve_cnt != CW'(STARVE_LIM)) begin
            starve_cnt_next = starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= inj_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            starve     <= 1'b0;
            inj_done   <= 1'b0;
            nout       <= '0;
            sout       <= '0;
            eout       <= '0;
            wout       <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
            starve_cnt <= starve_cnt_next;
            starve     <= (starve_cnt_next == CW'(STARVE_LIM));
            inj_done   <= pop_en;
            nout       <= slot_out[0];
            sout       <= slot_out[1];
            eout       <= slot_out[2];
            wout       <= slot_out[3];
        end
    end
endmodule

// File: tb/tb_injector_stage.sv
// tb/tb_injector_stage.sv - directed bench for injector_stage with a queue-based reference model
module tb_injector_stage;
    localparam int FLIT_W     = 11;
    localparam int DEPTH      = 4;
    localparam int STARVE_LIM = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLIT_W-1:0] northad, southad, eastad, westad;
    logic [FLIT_W-1:0] inj_flit;
    logic              inj_valid;
    logic              inj_ready;
    logic [FLIT_W-1:0] nout, sout, eout, wout;
    logic [2:0]        occ;
    logic              inj_done;
    logic              starve;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [FLIT_W-1:0] ch [4];
        logic              done;
        logic [2:0]        occ;
        logic              starve;
        logic              ready;
    } exp_t;

    exp_t              sb [$];
    logic [FLIT_W-1:0] mq [$];
    int                mcnt = 0;

    injector_stage #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
        .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .nout(nout), .sout(sout), .eout(eout), .wout(wout),
        .occ(occ), .inj_done(inj_done), .starve(starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [FLIT_W-1:0] n, s, e, w);
        northad = n; southad = s; eastad = e; westad = w;
    endtask

    // Model the coming edge, queue its expected outputs, clock, then compare.
    task automatic step();
        exp_t x;
        int   sz;
        logic pop;
        logic placed;
        sz  = mq.size();
        x.ch[0] = northad; x.ch[1] = southad; x.ch[2] = eastad; x.ch[3] = westad;
        pop = 1'b0;
        placed = 1'b0;
        if (sz > 0) begin
            for (int i = 0; i < 4; i++) begin
                if (!placed && x.ch[i][10:9] == 2'b00) begin
                    x.ch[i] = mq.pop_front();
                    placed  = 1'b1;
                    pop     = 1'b1;
                end
            end
        end
        if (inj_valid && sz < DEPTH && inj_flit[10:9] != 2'b00) mq.push_back(inj_flit);
        if (pop || sz == 0) mcnt = 0;
        else if (mcnt < STARVE_LIM) mcnt++;
        x.done   = pop;
        x.occ    = 3'(mq.size());
        x.starve = (mcnt == STARVE_LIM);
        x.ready  = (mq.size() < DEPTH);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("nout", 32'(nout), 32'(x.ch[0]));
        chk("sout", 32'(sout), 32'(x.ch[1]));
        chk("eout", 32'(eout), 32'(x.ch[2]));
        chk("wout", 32'(wout), 32'(x.ch[3]));
        chk("inj_done", 32'(inj_done), 32'(x.done));
        chk("occ", 32'(occ), 32'(x.occ));
        chk("starve", 32'(starve), 32'(x.starve));
        chk("inj_ready", 32'(inj_ready), 32'(x.ready));
    endtask

    task automatic push(input logic [FLIT_W-1:0] f);
        inj_flit = f; inj_valid = 1'b1;
        step();
        inj_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in('0, '0, '0, '0);
        inj_flit = '0; inj_valid = 1'b0;
        #3;
        chk("rst_nout", 32'(nout), 32'h0);
        chk("rst_occ", 32'(occ), 32'h0);
        chk("rst_ready", 32'(inj_ready), 32'h1);
        chk("rst_done", 32'(inj_done), 32'h0);
        chk("rst_starve", 32'(starve), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single flit into an all-empty channel set
        push(11'h5A3);
        chk("t1_occ1", 32'(occ), 32'h1);
        step();
        chk("t1_nout", 32'(nout), 32'h5A3);
        chk("t1_done", 32'(inj_done), 32'h1);
        chk("t1_occ0", 32'(occ), 32'h0);
        step();
        chk("t1_done_pulse", 32'(inj_done), 32'h0);

        // first-empty priority with two queued flits
        set_in(11'h611, 11'h612, 11'h613, 11'h422);
        push(11'h2C1);
        push(11'h2C2);
        set_in(11'h611, 11'h000, 11'h000, 11'h422);
        step();
        chk("t2_sout_a", 32'(sout), 32'h2C1);
        chk("t2_eout_0", 32'(eout), 32'h0);
        chk("t2_nout", 32'(nout), 32'h611);
        chk("t2_wout", 32'(wout), 32'h422);
        step();
        chk("t2_sout_b", 32'(sout), 32'h2C2);
        step();

        // fill to DEPTH, refuse when full, ready returns a cycle after the pop, order kept across wrap
        set_in(11'h611, 11'h612, 11'h613, 11'h422);
        for (int k = 0; k < DEPTH; k++) push(11'h2D0 + 11'(k));
        chk("t3_ready_full", 32'(inj_ready), 32'h0);
        chk("t3_occ_full", 32'(occ), 32'(DEPTH));
        push(11'h2FF);
        set_in(11'h611, 11'h612, 11'h613, 11'h000);
        step();
        chk("t3_wout_pop", 32'(wout), 32'h2D0);
        chk("t3_ready_back", 32'(inj_ready), 32'h1);
        set_in(11'h611, 11'h612, 11'h613, 11'h422);
        push(11'h2E0);
        set_in('0, '0, '0, '0);
        for (int k = 0; k < DEPTH; k++) step();
        chk("t3_wrap_last", 32'(nout), 32'h2E0);
        step();

        // starvation after exactly STARVE_LIM blocked edges
        set_in(11'h611, 11'h612, 11'h613, 11'h422);
        push(11'h3A5);
        for (int k = 1; k <= STARVE_LIM; k++) begin
            step();
            chk("t4_starve", 32'(starve), 32'(k == STARVE_LIM));
        end
        set_in(11'h000, 11'h612, 11'h613, 11'h422);
        step();
        chk("t4_starve_clear", 32'(starve), 32'h0);
        chk("t4_nout", 32'(nout), 32'h3A5);

        // gs==00 push is accepted but discarded
        set_in('0, '0, '0, '0);
        push(11'h07F);
        chk("t5_occ", 32'(occ), 32'h0);
        chk("t5_ready", 32'(inj_ready), 32'h1);
        step();
        chk("t5_no_inject", 32'(inj_done), 32'h0);

        // asynchronous reset with three queued flits
        set_in(11'h611, 11'h612, 11'h613, 11'h422);
        push(11'h2A1);
        push(11'h2A2);
        push(11'h2A3);
        chk("t6_occ3", 32'(occ), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_nout", 32'(nout), 32'h0);
        chk("t6_wout", 32'(wout), 32'h0);
        chk("t6_occ", 32'(occ), 32'h0);
        chk("t6_ready", 32'(inj_ready), 32'h1);
        #2 rst_n = 1'b1;
        mq.delete();
        mcnt = 0;
        set_in('0, '0, '0, '0);
        step();
        chk("t6_no_inject1", 32'(inj_done), 32'h0);
        step();
        chk("t6_no_inject2", 32'(nout), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
